// File: rtl/uart_hex_streamer.sv
// uart_hex_streamer
// Prints a captured data word as ASCII hex, most significant nibble first,
// one character per UART frame, optionally terminated by CR LF. The block
// talks to a byte-wide UART transmitter through a valid strobe and watches
// the transmitter's active/done signals to pace each character.
module uart_hex_streamer #(
    parameter int DATA_BYTES  = 32,
    parameter bit UPPER_CASE  = 1'b0,
    parameter bit APPEND_CRLF = 1'b1
) (
    input  logic                    i_Clock,
    input  logic                    i_Reset,
    input  logic                    i_Start,
    input  logic [DATA_BYTES*8-1:0] i_Data,
    output logic                    o_Busy,
    output logic                    o_Done,
    output logic                    o_Tx_DV,
    output logic [7:0]              o_Tx_Byte,
    input  logic                    i_Tx_Active,
    input  logic                    i_Tx_Done
);

    localparam int DATA_W  = DATA_BYTES * 8;
    localparam int N_CHARS = 2 * DATA_BYTES + (APPEND_CRLF ? 2 : 0);
    localparam int CNT_W   = $clog2(N_CHARS + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHECK     = 2'd1,
        SEND      = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    // Map one nibble onto its ASCII hex digit.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        logic [7:0] ch;
        if (nib < 4'd10) begin
            ch = 8'h30 + {4'h0, nib};
        end else if (UPPER_CASE) begin
            ch = 8'h41 + {4'h0, nib} - 8'd10;
        end else begin
            ch = 8'h61 + {4'h0, nib} - 8'd10;
        end
        return ch;
    endfunction

    // Pick the character for the current position: the counter still holds
    // the number of characters left, so 2 and 1 are the CR and LF slots.
    function automatic logic [7:0] next_char(input logic [3:0]       nib,
                                             input logic [CNT_W-1:0] left);
        logic [7:0] ch;
        if (APPEND_CRLF && (left == CNT_W'(2))) begin
            ch = 8'h0D;
        end else if (APPEND_CRLF && (left == CNT_W'(1))) begin
            ch = 8'h0A;
        end else begin
            ch = hex_ascii(nib);
        end
        return ch;
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [DATA_W-1:0]  shift_r;
    logic [DATA_W-1:0]  shift_s;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_s;
    logic               busy_r;
    logic               busy_s;
    logic               done_r;
    logic               done_s;
    logic               tx_dv_r;
    logic               tx_dv_s;
    logic [7:0]         tx_byte_r;
    logic [7:0]         tx_byte_s;

    // Next-state, datapath and next-output decode; outputs are registered
    // from the next state so they line up exactly with the state they describe.
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        count_s   = count_r;
        done_s    = 1'b0;
        tx_byte_s = tx_byte_r;

        case (state_r)
            IDLE: begin
                if (i_Start) begin
                    shift_s = i_Data;
                    count_s = CNT_W'(N_CHARS);
                    state_s = CHECK;
                end else begin
                    state_s = IDLE;
                end
            end

            CHECK: begin
                if (i_Tx_Active) begin
                    state_s = CHECK;
                end else begin
                    state_s   = SEND;
                    tx_byte_s = next_char(shift_r[DATA_W-1 -: 4], count_r);
                end
            end

            SEND: begin
                // Once the hex digits are exhausted the register is all zero,
                // so shifting through the CR/LF slots is harmless.
                shift_s = {shift_r[DATA_W-5:0], 4'h0};
                state_s = WAIT_DONE;
            end

            WAIT_DONE: begin
                if (i_Tx_Done) begin
                    count_s = count_r - CNT_W'(1);
                    if (count_r == CNT_W'(1)) begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = CHECK;
                    end
                end else begin
                    state_s = WAIT_DONE;
                end
            end

            default: begin
                state_s = IDLE;
            end
        endcase

        tx_dv_s = (state_s == SEND);
        busy_s  = (state_s != IDLE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_r   <= IDLE;
            shift_r   <= '0;
            count_r   <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            tx_dv_r   <= 1'b0;
            tx_byte_r <= 8'h00;
        end else begin
            state_r   <= state_s;
            shift_r   <= shift_s;
            count_r   <= count_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            tx_dv_r   <= tx_dv_s;
            tx_byte_r <= tx_byte_s;
        end
    end

    assign o_Busy    = busy_r;
    assign o_Done    = done_r;
    assign o_Tx_DV   = tx_dv_r;
    assign o_Tx_Byte = tx_byte_r;

endmodule

// File: tb/tb_uart_hex_streamer.sv
// Bench for uart_hex_streamer: two instances (2-byte lower-case with CR LF,
// 1-byte upper-case without), each driven by a simple UART transmitter model
// that finishes a frame 10 cycles after its valid strobe. Captured bytes are
// compared against an ASCII-hex reference built from the data word.
module tb_uart_hex_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- instance A: DATA_BYTES=2, lower case, CR LF ----------
    logic        a_reset = 1'b1;
    logic        a_start = 1'b0;
    logic [15:0] a_data  = 16'h0000;
    logic        a_busy, a_done, a_dv;
    logic [7:0]  a_byte;
    logic        a_tx_active;
    logic        a_tx_done = 1'b0;
    bit          a_uact = 1'b0;
    bit          a_hold = 1'b0;
    int          a_cnt = 0;
    logic [7:0]  a_got[$];
    int          a_dv_cnt = 0;
    int          a_done_cnt = 0;
    bit          a_prev_dv = 1'b0;

    assign a_tx_active = a_uact | a_hold;

    uart_hex_streamer #(.DATA_BYTES(2), .UPPER_CASE(1'b0), .APPEND_CRLF(1'b1)) dut_a (
        .i_Clock(clk), .i_Reset(a_reset), .i_Start(a_start), .i_Data(a_data),
        .o_Busy(a_busy), .o_Done(a_done), .o_Tx_DV(a_dv), .o_Tx_Byte(a_byte),
        .i_Tx_Active(a_tx_active), .i_Tx_Done(a_tx_done)
    );

    // ---------------- instance B: DATA_BYTES=1, upper case, no CR LF -------
    logic        b_reset = 1'b1;
    logic        b_start = 1'b0;
    logic [7:0]  b_data  = 8'h00;
    logic        b_busy, b_done, b_dv;
    logic [7:0]  b_byte;
    logic        b_tx_done = 1'b0;
    bit          b_uact = 1'b0;
    int          b_cnt = 0;
    logic [7:0]  b_got[$];
    int          b_done_cnt = 0;
    int          b_td_seen = 0;

    uart_hex_streamer #(.DATA_BYTES(1), .UPPER_CASE(1'b1), .APPEND_CRLF(1'b0)) dut_b (
        .i_Clock(clk), .i_Reset(b_reset), .i_Start(b_start), .i_Data(b_data),
        .o_Busy(b_busy), .o_Done(b_done), .o_Tx_DV(b_dv), .o_Tx_Byte(b_byte),
        .i_Tx_Active(b_uact), .i_Tx_Done(b_tx_done)
    );

    // Monitor and UART model for A; frames run to completion regardless of reset.
    always @(negedge clk) begin
        if (a_dv) begin
            check_eq("a_dv_while_active", 32'(a_tx_active), 32'd0);
            check_eq("a_dv_single_cycle", 32'(a_prev_dv), 32'd0);
            a_got.push_back(a_byte);
            a_dv_cnt++;
        end
        if (a_done) begin
            a_done_cnt++;
            check_eq("a_busy_in_done_cycle", 32'(a_busy), 32'd0);
        end
        a_prev_dv = a_dv;
        a_tx_done = 1'b0;
        if (a_dv) begin
            a_cnt  = 10;
            a_uact = 1'b1;
        end else if (a_cnt > 0) begin
            a_cnt--;
            if (a_cnt == 0) begin
                a_tx_done = 1'b1;
                a_uact    = 1'b0;
            end
        end
    end

    // Monitor and UART model for B, plus done-after-2nd-frame timing check.
    always @(negedge clk) begin
        if (b_tx_done) begin
            b_td_seen++;
            if (b_td_seen == 2) check_eq("b_done_after_2nd_txdone", 32'(b_done), 32'd1);
        end
        if (b_dv) b_got.push_back(b_byte);
        if (b_done) b_done_cnt++;
        b_tx_done = 1'b0;
        if (b_dv) begin
            b_cnt  = 10;
            b_uact = 1'b1;
        end else if (b_cnt > 0) begin
            b_cnt--;
            if (b_cnt == 0) begin
                b_tx_done = 1'b1;
                b_uact    = 1'b0;
            end
        end
    end

    // ---------------- reference model --------------------------------------
    logic [7:0] exp_q[$];

    task automatic model_chars(input logic [31:0] d, input int nbytes, input bit upper, input bit crlf);
        for (int k = 2 * nbytes - 1; k >= 0; k--) begin
            int n;
            n = int'((d >> (4 * k)) & 32'hF);
            if (n < 10) exp_q.push_back(8'(48 + n));
            else        exp_q.push_back(8'((upper ? 65 : 97) + n - 10));
        end
        if (crlf) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic compare_stream(input string tag, input int base, input bit is_b);
        int got_n;
        int lim;
        got_n = is_b ? (b_got.size() - base) : (a_got.size() - base);
        check_eq({tag, "_count"}, 32'(got_n), 32'(exp_q.size()));
        lim = (got_n < exp_q.size()) ? got_n : exp_q.size();
        for (int i = 0; i < lim; i++) begin
            logic [7:0] g;
            g = is_b ? b_got[base + i] : a_got[base + i];
            check_eq($sformatf("%s_byte%0d", tag, i), 32'(g), 32'(exp_q[i]));
        end
    endtask

    task automatic a_pulse(input logic [15:0] d);
        a_data  = d;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic a_wait_done(input string tag, input int limit);
        int i;
        i = 0;
        while (a_done !== 1'b1 && i < limit) begin
            @(negedge clk);
            i++;
        end
        check_eq({tag, "_done_seen"}, 32'(a_done), 32'd1);
    endtask

    task automatic a_reset_vals(input string tag);
        check_eq({tag, "_busy"}, 32'(a_busy), 32'd0);
        check_eq({tag, "_done"}, 32'(a_done), 32'd0);
        check_eq({tag, "_dv"},   32'(a_dv),   32'd0);
        check_eq({tag, "_byte"}, 32'(a_byte), 32'd0);
    endtask

    int base, dv0, dc0, dvm, dcm, j;
    logic [15:0] d1, d2;

    initial begin
        repeat (3) @(negedge clk);
        a_reset_vals("reset");
        check_eq("b_reset_busy", 32'(b_busy), 32'd0);
        check_eq("b_reset_byte", 32'(b_byte), 32'd0);
        a_reset = 1'b0;
        b_reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic stream of 0xA53C
        exp_q.delete(); model_chars(32'hA53C, 2, 1'b0, 1'b1);
        base = a_got.size(); dc0 = a_done_cnt;
        a_pulse(16'hA53C);
        check_eq("t1_busy_after_start", 32'(a_busy), 32'd1);
        a_wait_done("t1", 2000);
        repeat (3) @(negedge clk);
        compare_stream("t1", base, 1'b0);
        check_eq("t1_done_pulses", 32'(a_done_cnt - dc0), 32'd1);
        check_eq("t1_busy_after", 32'(a_busy), 32'd0);

        // Restart requests and data changes mid-stream are ignored
        exp_q.delete(); model_chars(32'hA53C, 2, 1'b0, 1'b1);
        base = a_got.size(); dc0 = a_done_cnt;
        a_pulse(16'hA53C);
        a_data = 16'h1111;
        repeat (25) @(negedge clk);
        a_start = 1'b1;
        repeat (3) @(negedge clk);
        a_start = 1'b0;
        repeat (20) @(negedge clk);
        a_pulse(16'h1111);
        a_wait_done("t2", 2000);
        repeat (3) @(negedge clk);
        compare_stream("t2", base, 1'b0);
        check_eq("t2_done_pulses", 32'(a_done_cnt - dc0), 32'd1);

        // Reset after the third character aborts the stream
        dv0 = a_dv_cnt; dc0 = a_done_cnt;
        a_pulse(16'hA53C);
        j = 0;
        while ((a_dv_cnt - dv0) < 3 && j < 2000) begin
            @(negedge clk);
            j++;
        end
        check_eq("t3_third_dv", 32'(a_dv_cnt - dv0), 32'd3);
        a_reset = 1'b1;
        @(negedge clk);
        a_reset_vals("t3_reset");
        a_reset = 1'b0;
        dvm = a_dv_cnt; dcm = a_done_cnt;
        repeat (3) @(negedge clk);
        check_eq("t3_no_dv_after_reset", 32'(a_dv_cnt - dvm), 32'd0);
        check_eq("t3_no_done_after_reset", 32'(a_done_cnt - dc0), 32'd0);
        // New stream while the aborted frame is still on the wire
        exp_q.delete(); model_chars(32'h00FF, 2, 1'b0, 1'b1);
        base = a_got.size(); dc0 = a_done_cnt;
        a_pulse(16'h00FF);
        a_wait_done("t3b", 2000);
        repeat (3) @(negedge clk);
        compare_stream("t3b", base, 1'b0);
        check_eq("t3b_done_pulses", 32'(a_done_cnt - dc0), 32'd1);

        // Transmitter busy at stream start holds off the first character
        repeat (15) @(negedge clk);
        d1 = 16'($urandom_range(0, 65535));
        exp_q.delete(); model_chars(32'(d1), 2, 1'b0, 1'b1);
        base = a_got.size(); dv0 = a_dv_cnt;
        a_hold = 1'b1;
        a_pulse(d1);
        repeat (48) @(negedge clk);
        check_eq("t4_no_dv_while_active", 32'(a_dv_cnt - dv0), 32'd0);
        a_hold = 1'b0;
        @(negedge clk);
        check_eq("t4_dv_after_fall", 32'(a_dv), 32'd1);
        a_wait_done("t4", 2000);
        repeat (3) @(negedge clk);
        compare_stream("t4", base, 1'b0);

        // Back-to-back streams with start in the done cycle
        d1 = 16'($urandom_range(0, 65535));
        d2 = 16'($urandom_range(0, 65535));
        exp_q.delete();
        model_chars(32'(d1), 2, 1'b0, 1'b1);
        model_chars(32'(d2), 2, 1'b0, 1'b1);
        base = a_got.size(); dv0 = a_dv_cnt; dc0 = a_done_cnt;
        a_pulse(d1);
        a_wait_done("t5a", 2000);
        a_pulse(d2);
        check_eq("t5_no_gap_busy", 32'(a_busy), 32'd1);
        a_wait_done("t5b", 2000);
        repeat (3) @(negedge clk);
        compare_stream("t5", base, 1'b0);
        check_eq("t5_total_dv", 32'(a_dv_cnt - dv0), 32'd12);
        check_eq("t5_done_pulses", 32'(a_done_cnt - dc0), 32'd2);

        // Randomized streams with random gaps and spurious start requests
        for (int r = 0; r < 6; r++) begin
            d1 = 16'($urandom_range(0, 65535));
            exp_q.delete(); model_chars(32'(d1), 2, 1'b0, 1'b1);
            base = a_got.size();
            repeat ($urandom_range(0, 4)) @(negedge clk);
            a_pulse(d1);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 40)) @(negedge clk);
                a_pulse(16'($urandom));
            end
            a_wait_done($sformatf("rnd%0d", r), 2000);
            @(negedge clk);
            compare_stream($sformatf("rnd%0d", r), base, 1'b0);
        end

        // Instance B: upper case, no CR LF, 0xF0
        exp_q.delete(); model_chars(32'hF0, 1, 1'b1, 1'b0);
        base = b_got.size();
        b_data  = 8'hF0;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        j = 0;
        while (b_done !== 1'b1 && j < 2000) begin
            @(negedge clk);
            j++;
        end
        check_eq("b_done_seen", 32'(b_done), 32'd1);
        repeat (15) @(negedge clk);
        compare_stream("b", base, 1'b1);
        check_eq("b_done_pulses", 32'(b_done_cnt), 32'd1);
        check_eq("b_busy_after", 32'(b_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_hex_streamer.md
UART_HEX_STREAMER -- requirements
Module: uart_hex_streamer

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 32, number of bytes in i_Data (256-bit ECC word).
REQ-002 SHALL have parameter UPPER_CASE, default 0; 0 emits hex letters as 'a'-'f', 1 emits them as 'A'-'F'.
REQ-003 SHALL have parameter APPEND_CRLF, default 1; 1 appends 0x0D, 0x0A after the hex digits.
REQ-004 SHALL have port i_Clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port i_Start, input, 1 bit: request to stream i_Data.
REQ-007 SHALL have port i_Data, input, DATA_BYTES*8 bits: word to print, MSB first.
REQ-008 SHALL have port o_Busy, output, 1 bit: a stream is in progress.
REQ-009 SHALL have port o_Done, output, 1 bit: one-cycle pulse on stream completion.
REQ-010 SHALL have port o_Tx_DV, output, 1 bit: byte-valid strobe to the UART transmitter.
REQ-011 SHALL have port o_Tx_Byte, output, 8 bits: ASCII byte to the UART transmitter.
REQ-012 SHALL have port i_Tx_Active, input, 1 bit: transmitter frame in progress.
REQ-013 SHALL have port i_Tx_Done, input, 1 bit: transmitter one-cycle frame-complete pulse.

Function
REQ-014 SHALL use states IDLE, CHECK, SEND, WAIT_DONE.
REQ-015 IDLE: on i_Start=1, SHALL capture i_Data into an internal shift register, load the character counter with N, and go to CHECK. N = 2*DATA_BYTES, plus 2 when APPEND_CRLF=1.
REQ-016 SHALL ignore i_Start in every state except IDLE; i_Data changes after capture SHALL NOT affect output.
REQ-017 CHECK: SHALL wait while i_Tx_Active=1, then go to SEND.
REQ-018 SEND: SHALL drive o_Tx_DV=1 for exactly one cycle with o_Tx_Byte valid in that same cycle, then go to WAIT_DONE.
REQ-019 o_Tx_Byte SHALL hold its value from the SEND cycle until the next SEND cycle.
REQ-020 Hex digit order SHALL be the most significant nibble of the captured word first, shifting left 4 bits per character.
REQ-021 Nibble mapping SHALL be: 0-9 -> 0x30+n; 10-15 -> 0x61+(n-10), or 0x41+(n-10) when UPPER_CASE=1.
REQ-022 When APPEND_CRLF=1, the last two characters SHALL be 0x0D then 0x0A.
REQ-023 WAIT_DONE: on i_Tx_Done=1, SHALL decrement the counter; if the counter is still nonzero go to CHECK, else go to IDLE and pulse o_Done.
REQ-024 The next o_Tx_DV SHALL occur no earlier than 1 cycle after the i_Tx_Done pulse, and never while i_Tx_Active=1.
REQ-025 o_Done SHALL be high for exactly one cycle: the first IDLE cycle after the last i_Tx_Done.
REQ-026 o_Busy SHALL be 0 in IDLE (including the o_Done cycle) and 1 in every other state.
REQ-027 i_Start=1 in the o_Done cycle SHALL be accepted, giving back-to-back streams.
REQ-028 Exactly N o_Tx_DV pulses SHALL be issued per accepted i_Start.
REQ-029 i_Tx_Done seen outside WAIT_DONE SHALL be ignored.
REQ-030 The counter SHALL be clog2(N+1) bits wide; there is no wrap-around, since the counter is never decremented at zero.

Reset
REQ-031 i_Reset=1 SHALL, at the next edge, force state IDLE, o_Busy=0, o_Done=0, o_Tx_DV=0, o_Tx_Byte=0x00, counter=0, shift register=0.
REQ-032 Reset has priority over i_Start and i_Tx_Done in the same cycle.
REQ-033 Reset mid-stream SHALL abort the stream with no further o_Tx_DV and no o_Done; a transmitter frame already in flight completes untouched.
REQ-034 The next stream after reset SHALL wait in CHECK until i_Tx_Active=0.

Verification
REQ-035 DATA_BYTES=2, defaults, i_Data=0xA53C, i_Start pulse, UART model done 10 cycles after each DV -> bytes 0x61,0x35,0x33,0x63,0x0D,0x0A; one o_Done; o_Busy low afterwards.
REQ-036 UPPER_CASE=1, APPEND_CRLF=0, DATA_BYTES=1, i_Data=0xF0 -> bytes 0x46,0x30 only; o_Done one cycle after the 2nd i_Tx_Done.
REQ-037 i_Start re-pulsed with i_Data=0x1111 during a 0xA53C stream -> output identical to REQ-035; no extra DV.
REQ-038 i_Reset asserted after the 3rd DV -> no further DV, no o_Done, all outputs at reset values; a new i_Start=0x00FF gives 0x30,0x30,0x66,0x66,0x0D,0x0A.
REQ-039 i_Tx_Active held 1 for 50 cycles at the start of a stream -> no DV until the cycle after it falls; then normal stream.
REQ-040 i_Start asserted in the o_Done cycle -> second stream starts with no idle gap; total DV count 2N.
